// File: rtl/program_loader.sv
// Nibble-serial program loader: fills a 16x4 program memory from a host handshake,
// optionally verifies a modulo-16 checksum, then serves combinational CPU fetches.
module program_loader #(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_load_start,
  input  logic       i_data_valid,
  input  logic [3:0] i_data_in,
  output logic       o_data_ready,
  input  logic [3:0] i_fetch_addr,
  output logic [3:0] o_fetch_data,
  output logic       o_cpu_run,
  output logic       o_load_done,
  output logic       o_load_error,
  output logic [4:0] o_word_count
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;
  localparam logic [DATA_W-1:0] HLT_OP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_sum;
  logic                r_run;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_sum_nxt;
  logic                w_run_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_xfer;

  assign o_data_ready = (r_state == S_LOAD) || (r_state == S_CSUM);
  assign w_xfer       = i_data_valid && o_data_ready;

  // State register and sticky status flags
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_run   <= w_run_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; a restart request outranks any same-cycle transfer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_cnt[ADDR_W-1:0];

    if (i_load_start) begin
      w_state_nxt = S_LOAD;
      w_cnt_nxt   = '0;
      w_sum_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer && (r_cnt < CNT_W'(DEPTH))) begin
            w_wr_en   = 1'b1;
            w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
            w_sum_nxt = DATA_W'(r_sum + i_data_in);
            if (r_cnt == CNT_W'(DEPTH - 1)) begin
              if (CSUM_EN) begin
                w_state_nxt = S_CSUM;
              end else begin
                w_state_nxt = S_RUN;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            if (i_data_in == r_sum) begin
              w_state_nxt = S_RUN;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_ERROR;
              w_err_nxt   = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    w_run_nxt = (w_state_nxt == S_RUN);
  end

  // Program memory, cleared by reset and written only by LOAD transfers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= i_data_in;
    end
  end

  assign o_fetch_data = (r_state == S_RUN) ? r_mem[i_fetch_addr] : HLT_OP;
  assign o_cpu_run    = r_run;
  assign o_load_done  = r_done;
  assign o_load_error = r_err;
  assign o_word_count = r_cnt;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have a single clock, and reset SHALL be asynchronous and active-low.
REQ-002 Parameter CSUM_EN, default 1, SHALL mean: 1 = a checksum nibble follows the program; 0 = no checksum phase.
REQ-003 clock  input  1  system clock; all state changes on posedge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 load_start  input  1  single-cycle request to begin a new program load.
REQ-006 data_valid  input  1  host nibble on data_in is valid this cycle.
REQ-007 data_in  input  4  program or checksum nibble from the host.
REQ-008 data_ready  output  1  loader accepts a nibble this cycle.
REQ-009 fetch_addr  input  4  CPU program-counter address.
REQ-010 fetch_data  output  4  instruction nibble returned to the CPU.
REQ-011 cpu_run  output  1  program is valid and the CPU may execute.
REQ-012 load_done  output  1  last load completed successfully (sticky until the next load_start).
REQ-013 load_error  output  1  last load failed its checksum (sticky until the next load_start).
REQ-014 word_count  output  5  number of program nibbles written in the current load, 0..16.

Function
REQ-015 Storage SHALL be a 16x4 program memory, addressed 0..15.
REQ-016 The state machine SHALL have the states IDLE, LOAD, CSUM, RUN and ERROR.
REQ-017 A handshake transfer SHALL occur on a posedge where data_valid=1 and data_ready=1; nothing is transferred otherwise.
REQ-018 data_ready SHALL be 1 in LOAD and CSUM and 0 in all other states.
REQ-019 In IDLE, RUN or ERROR, load_start=1 SHALL cause the following, next cycle:
- state goes to LOAD;
- word_count and write address clear to 0;
- running sum clears to 0;
- cpu_run, load_done and load_error clear to 0.
REQ-020 Memory contents SHALL be preserved on load_start and overwritten only by transfers.
REQ-021 On each LOAD transfer, the block SHALL:
- write data_in to mem[word_count[3:0]];
- increment word_count;
- add data_in to the running sum, 4-bit modulo 16, carry discarded.
REQ-022 When the transfer making word_count=16 completes, the next state SHALL be CSUM if CSUM_EN=1, or RUN if CSUM_EN=0.
REQ-023 On a CSUM transfer, if data_in equals the running sum, the next state SHALL be RUN with load_done=1; otherwise it SHALL be ERROR with load_error=1.
REQ-024 Entering RUN SHALL set cpu_run=1 on the same edge as load_done=1.
REQ-025 cpu_run SHALL be 1 only in RUN.
REQ-026 In RUN, fetch_data SHALL equal mem[fetch_addr] combinationally, with zero-cycle latency.
REQ-027 Outside RUN, fetch_data SHALL be 4'b1111 (HLT opcode), so a CPU fetching early halts.
REQ-028 load_start=1 in LOAD or CSUM SHALL restart the load as in REQ-019. load_start SHALL take priority over a simultaneous transfer, and that nibble SHALL be discarded and not written.
REQ-029 word_count SHALL saturate at 16; no LOAD write occurs once word_count=16.
REQ-030 A reads-during-write hazard cannot occur: writes happen only outside RUN and fetches are valid only in RUN.

Reset
REQ-031 On reset_n=0, immediately and independent of clock, the block SHALL enter this state:
- state IDLE;
- word_count=0, sum=0;
- cpu_run=0, load_done=0, load_error=0;
- data_ready=0, fetch_data=4'b1111;
- all 16 memory words = 4'b0000.
REQ-032 Reset asserted mid-load SHALL abandon the load. After release the block SHALL stay in IDLE until load_start.
REQ-033 Deassertion of reset SHALL take effect on the first posedge after reset_n rises.

Verification
REQ-034 Good load: load_start, then nibbles 0..15 in order with valid held high, then checksum 4'h8 (sum 120 mod 16) -> load_done=1, cpu_run=1, and fetch_addr=5 returns 4'h5.
REQ-035 Bad checksum: same 16 nibbles, then checksum 4'h3 -> load_error=1, cpu_run=0, and fetch_data=4'hF for every fetch_addr.
REQ-036 Gapped handshake: data_valid toggled 1/0 every cycle over a 16-nibble load -> exactly 16 writes, word_count steps by 1 only on valid cycles, final contents correct.
REQ-037 Restart collision:
- stimulus: load_start and data_valid both high, with word_count=7;
- response: word_count=0 next cycle, that nibble not written, and mem[7] retains its old value.
REQ-038 Async reset in CSUM: pull reset_n low between clock edges -> cpu_run=0 and data_ready=0 immediately, and mem[0..15]=0.
REQ-039 CSUM_EN=0: load 16 nibbles of 4'hA -> RUN directly after the 16th transfer, data_ready=0 the next cycle, and fetch_data=4'hA for all addresses.
